// File: rtl/prf_free_list.sv
// Physical-register free-list allocator: circular buffer of free PRF tags with a
// speculative head (rename) and a commit head, so a flush can roll allocations back.
module prf_free_list #(
  parameter  int PRF_NUM = 32,
  parameter  int ARF_NUM = 8,
  parameter  int TAG_W   = $clog2(PRF_NUM),
  localparam int DEPTH   = PRF_NUM - ARF_NUM,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_old_tag,
  input  logic             flush,
  output logic [CNT_W-1:0] free_cnt,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [TAG_W-1:0] tag_buf_q [DEPTH];
  ptr_t             spec_head_q, spec_head_d;
  ptr_t             commit_head_q, commit_head_d;
  ptr_t             tail_q, tail_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             do_alloc, do_commit;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign alloc_ready   = (spec_cnt_q != '0);
  assign alloc_tag     = tag_buf_q[spec_head_q];
  assign free_cnt      = spec_cnt_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

  always_comb begin
    do_commit     = commit_valid && (spec_cnt_q != CNT_W'(DEPTH));
    do_alloc      = alloc_req && alloc_ready && !flush;
    commit_head_d = do_commit ? ptr_inc(commit_head_q) : commit_head_q;
    tail_d        = do_commit ? ptr_inc(tail_q) : tail_q;
    spec_head_d   = spec_head_q;
    spec_cnt_d    = spec_cnt_q;
    // Flush rewinds to the commit head as it stands after this cycle's commit.
    if (flush) begin
      spec_head_d = commit_head_d;
      spec_cnt_d  = CNT_W'(DEPTH);
    end else begin
      if (do_alloc) spec_head_d = ptr_inc(spec_head_q);
      case ({do_commit, do_alloc})
        2'b10:   spec_cnt_d = spec_cnt_q + 1'b1;
        2'b01:   spec_cnt_d = spec_cnt_q - 1'b1;
        default: spec_cnt_d = spec_cnt_q;
      endcase
    end
    err_ovf_d = err_ovf_q | (commit_valid && !do_commit);
    err_unf_d = err_unf_q | (alloc_req && !alloc_ready && !flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tag_buf_q[i] <= TAG_W'(ARF_NUM + i);
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      spec_cnt_q    <= CNT_W'(DEPTH);
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
    end else begin
      if (do_commit) tag_buf_q[tail_q] <= commit_old_tag;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      spec_cnt_q    <= spec_cnt_d;
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
    end
  end

endmodule
